alu_share_ctrl: RTL and testbench

- Sequences the single 16-bit ALU of the cpu and shares it between two requesters: requester 0 (execute stage) and requester 1 (address/branch-target unit).
- Arbitrates round-robin and latches operands.
- Decodes the 4-bit instruction opcode into the 7-bit ALUop, then captures the ALU result into a response register with valid/ready backpressure.
- Owns the Z/V/N flag register, which only requester-0 operations update.

---
 rtl/alu_share_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 16-bit ALU between two requesters.
//   req0 = execute stage (owns the Z/V/N flags), req1 = address/branch unit.
// Round-robin grant, operand/opcode latching, opcode -> ALUop decode, and a
// response register with valid/ready backpressure.
// Ports:
//   clk, rst                 clock, async active-high reset
//   reqN_valid/ready         request handshake (N = 0,1)
//   reqN_opcode/a/b          4-bit opcode and 16-bit operands
//   rsp_valid/ready          response handshake
//   rsp_id/data/ovfl         owner, result and overflow of the response
//   alu_a/b/op               drive the shared ALU (valid during EXEC only)
//   alu_out/ovfl             ALU result back
//   flag_z/v/n               flag register (req0 ops only)
//   busy                     an op is in EXEC or DONE
module alu_share_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ALUOP_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_opcode,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_opcode,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_ovfl,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_ovfl,
  output logic               flag_z,
  output logic               flag_v,
  output logic               flag_n,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 iss_id_q, iss_id_d;
  logic [3:0]           iss_opc_q, iss_opc_d;
  logic [DATA_W-1:0]    iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic [ALUOP_W-1:0]   iss_op_q, iss_op_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_ovfl_q, rsp_ovfl_d;
  logic                 z_q, z_d, v_q, v_d, n_q, n_d;

  logic can_accept, grant1, accept;

  // {outSel[1:0], sat, red, sub, shift[1:0]}; 1xxx is plain address add
  function automatic logic [ALUOP_W-1:0] decode_op(input logic [3:0] opc);
    logic [ALUOP_W-1:0] op;
    op = '0;
    if (!opc[3]) begin
      case (opc[2:0])
        3'd0:    op = 7'b00_1_0_0_00;
        3'd1:    op = 7'b00_1_0_1_00;
        3'd2:    op = 7'b00_0_1_0_00;
        3'd3:    op = 7'b01_0_0_0_00;
        3'd4:    op = 7'b10_0_0_0_00;
        3'd5:    op = 7'b10_0_0_0_01;
        3'd6:    op = 7'b10_0_0_0_10;
        default: op = 7'b00_1_1_0_11;
      endcase
    end
    return op;
  endfunction

  // A new op can enter while idle, or in DONE on the very cycle the
  // current result is consumed (back-to-back issue).
  assign can_accept = (state_q == IDLE) || (state_q == DONE && rsp_ready);
  assign grant1     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign req0_ready = can_accept && req0_valid && !grant1;
  assign req1_ready = can_accept && req1_valid && grant1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    iss_id_d     = iss_id_q;
    iss_opc_d    = iss_opc_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_op_d     = iss_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovfl_d   = rsp_ovfl_q;
    z_d          = z_q;
    v_d          = v_q;
    n_d          = n_q;

    if (state_q == DONE && rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d     = IDLE;
    end

    if (state_q == EXEC) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = iss_id_q;
      rsp_data_d  = alu_out;
      rsp_ovfl_d  = alu_ovfl;
      state_d     = DONE;
      if (!iss_id_q) begin
        case (iss_opc_q)
          4'd0, 4'd1: begin
            z_d = (alu_out == '0);
            v_d = alu_ovfl;
            n_d = alu_out[DATA_W-1];
          end
          4'd3, 4'd4, 4'd5, 4'd6: z_d = (alu_out == '0);
          default: ;
        endcase
      end
    end

    if (accept) begin
      last_grant_d = grant1;
      iss_id_d     = grant1;
      iss_opc_d    = grant1 ? req1_opcode : req0_opcode;
      iss_a_d      = grant1 ? req1_a : req0_a;
      iss_b_d      = grant1 ? req1_b : req0_b;
      iss_op_d     = decode_op(grant1 ? req1_opcode : req0_opcode);
      state_d      = EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      iss_id_q     <= 1'b0;
      iss_opc_q    <= '0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovfl_q   <= 1'b0;
      z_q          <= 1'b0;
      v_q          <= 1'b0;
      n_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      iss_id_q     <= iss_id_d;
      iss_opc_q    <= iss_opc_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_op_q     <= iss_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovfl_q   <= rsp_ovfl_d;
      z_q          <= z_d;
      v_q          <= v_d;
      n_q          <= n_d;
    end
  end

  // Issue regs feed the ALU directly: stable for all of EXEC, and they keep
  // the last issued op until the next accept.
  assign alu_a     = iss_a_q;
  assign alu_b     = iss_b_q;
  assign alu_op    = iss_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovfl  = rsp_ovfl_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized + directed bench for alu_share_ctrl. A behavioural ALU stands in
// for the real one; a one-deep transaction model predicts grants, responses
// and flags from the arbitration/latency/flag rules.
module tb_alu_share_ctrl;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_ovfl;
  logic [15:0] rsp_data, alu_a, alu_b, alu_out;
  logic [6:0] alu_op;
  logic alu_ovfl, flag_z, flag_v, flag_n, busy;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ovfl(rsp_ovfl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_ovfl(alu_ovfl),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .busy(busy));

  // behavioural ALU, with an override to force specific results
  logic ovr_en = 1'b0, ovr_ovfl = 1'b0;
  logic [15:0] ovr_out = '0;

  function automatic logic [16:0] fake_alu(input logic [6:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic v;
    r = '0; v = 1'b0;
    case (op[6:5])
      2'b00: if (op[3]) r = a ^ ~b;
             else if (op[2]) begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
             else begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      2'b01: r = a ^ b;
      2'b10: case (op[1:0])
               2'b00:   r = a << b[3:0];
               2'b01:   r = $signed(a) >>> b[3:0];
               default: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
             endcase
      default: r = a;
    endcase
    if (ovr_en) begin r = ovr_out; v = ovr_ovfl; end
    return {v, r};
  endfunction

  assign {alu_ovfl, alu_out} = fake_alu(alu_op, alu_a, alu_b);

  // ALUop table straight from the opcode list
  function automatic logic [6:0] spec_op(input logic [3:0] opc);
    logic [6:0] t [8];
    t = '{7'b0010000, 7'b0010100, 7'b0001000, 7'b0100000,
          7'b1000000, 7'b1000001, 7'b1000010, 7'b0011011};
    return opc[3] ? 7'b0000000 : t[opc[2:0]];
  endfunction

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction model: at most one op outstanding; age 0 = in EXEC
  typedef struct {
    logic id; logic [3:0] opc; logic [15:0] a, b, res; logic ov; int age;
  } op_t;
  op_t p;
  logic have_p, m_last, m_z, m_v, m_n;
  logic [1:0] acc;   // 0 none, 1 req0, 2 req1 (predicted for coming edge)
  logic rhs;
  int n_acc;
  logic [3:0] grant_log [$];

  task automatic mon();
    logic can, g1, e0, e1;
    can = !have_p || (p.age >= 1 && rsp_ready);
    g1  = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e0  = can && req0_valid && !g1;
    e1  = can && req1_valid && g1;
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("rsp_valid", 32'(rsp_valid), 32'(have_p && p.age >= 1));
    check("busy", 32'(busy), 32'(have_p));
    if (have_p && p.age >= 1) begin
      check("rsp_id", 32'(rsp_id), 32'(p.id));
      check("rsp_data", 32'(rsp_data), 32'(p.res));
      check("rsp_ovfl", 32'(rsp_ovfl), 32'(p.ov));
    end
    if (have_p && p.age == 0) begin
      check("alu_a", 32'(alu_a), 32'(p.a));
      check("alu_b", 32'(alu_b), 32'(p.b));
      check("alu_op", 32'(alu_op), 32'(spec_op(p.opc)));
    end
    check("flags", 32'({flag_z, flag_v, flag_n}), 32'({m_z, m_v, m_n}));
    acc = e0 ? 2'd1 : (e1 ? 2'd2 : 2'd0);
    rhs = have_p && p.age >= 1 && rsp_ready;
  endtask

  task automatic upd();
    if (have_p && p.age == 0) begin
      {p.ov, p.res} = fake_alu(spec_op(p.opc), p.a, p.b);
      p.age = 1;
      if (!p.id) begin
        if (p.opc <= 4'd1) begin m_z = (p.res == 0); m_v = p.ov; m_n = p.res[15]; end
        else if (p.opc >= 4'd3 && p.opc <= 4'd6) m_z = (p.res == 0);
      end
    end else if (rhs) have_p = 1'b0;
    if (acc != 2'd0) begin
      have_p = 1'b1; p.age = 0; p.id = (acc == 2'd2); m_last = p.id;
      p.opc = p.id ? req1_opcode : req0_opcode;
      p.a   = p.id ? req1_a : req0_a;
      p.b   = p.id ? req1_b : req0_b;
      n_acc++;
      grant_log.push_back({3'b0, p.id});
      if (p.id) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk); mon();
    @(posedge clk); #1; upd();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    have_p = 1'b0; m_last = 1'b1; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
    if (id) begin req1_valid = 1'b1; req1_opcode = opc; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_opcode = opc; req0_a = a; req0_b = b; end
  endtask

  initial begin
    rst = 1'b0; rsp_ready = 1'b0; n_acc = 0; acc = '0; rhs = 1'b0;
    req0_valid = 0; req0_opcode = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_a = 0; req1_b = 0;
    @(posedge clk); #1;
    do_reset();
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_ovfl, rsp_data}), 32'd0);
    check("rst_flags", 32'({flag_z, flag_v, flag_n}), 32'd0);
    check("rst_alu", 32'({alu_op, alu_a}), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_busy", 32'({busy, req0_ready, req1_ready}), 32'd0);

    // ADD 3+4 on req0, response held
    set_req(1'b0, 4'd0, 16'h0003, 16'h0004);
    #1 check("add_ready_same_cycle", 32'(req0_ready), 32'd1);
    step(); step();
    check("add_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 16'h0007}));
    check("add_aluop", 32'(alu_op), 32'(7'b0010000));
    check("add_zn", 32'({flag_z, flag_n}), 32'd0);
    rsp_ready = 1'b1; step();

    // both requesters continuously valid: grants alternate from req0
    do_reset();
    grant_log.delete(); n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (!req0_valid) set_req(1'b0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      if (!req1_valid) set_req(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      step();
    end
    check("alt_count", 32'(n_acc), 32'd8);
    foreach (grant_log[k]) check("alt_grant", 32'(grant_log[k]), 32'(k % 2));
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // req1 SUB 5-5 leaves flags alone; same on req0 sets Z
    set_req(1'b1, 4'd1, 16'h0005, 16'h0005); rsp_ready = 1'b0;
    step(); step();
    check("r1_sub", 32'({rsp_id, rsp_data}), 32'({1'b1, 16'h0000}));
    check("r1_flags", 32'({flag_z, flag_v, flag_n}), 32'({m_z, m_v, m_n}));
    rsp_ready = 1'b1; step();
    set_req(1'b0, 4'd1, 16'h0005, 16'h0005);
    step(); step();
    check("r0_sub_z", 32'(flag_z), 32'd1);

    // backpressure: 5 cycles held, then same-cycle accept on release
    rsp_ready = 1'b0; step();
    set_req(1'b0, 4'd3, 16'h00F0, 16'h0F0F); step(); step();
    begin
      logic [17:0] snap;
      snap = {rsp_valid, rsp_id, rsp_data};
      repeat (5) begin
        step();
        check("bp_hold", 32'({rsp_valid, rsp_id, rsp_data}), 32'(snap));
        check("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      end
    end
    rsp_ready = 1'b1; #1 check("bp_accept", 32'(req0_ready), 32'd1);
    step(); step();
    check("bp_next", 32'({rsp_valid, rsp_data}), 32'({1'b1, 16'h0FFF}));
    step();

    // forced overflow on ADD, then XOR to zero: Z set, V/N kept
    ovr_en = 1'b1; ovr_out = 16'h7FFF; ovr_ovfl = 1'b1;
    set_req(1'b0, 4'd0, 16'h7000, 16'h0FFF); step(); step();
    check("ovf_rsp", 32'(rsp_ovfl), 32'd1);
    check("ovf_vn", 32'({flag_v, flag_n}), 32'b10);
    step(); ovr_en = 1'b0;
    set_req(1'b0, 4'd3, 16'h1234, 16'h1234); step(); step();
    check("xor_zvn", 32'({flag_z, flag_v, flag_n}), 32'b110);
    step();

    // reset while in EXEC drops the op
    set_req(1'b1, 4'd2, 16'h1111, 16'h2222); step();
    rst = 1'b1; #1;
    check("rst_exec", 32'({busy, rsp_valid, rsp_id, rsp_ovfl, alu_op}), 32'd0);
    check("rst_exec_data", 32'({rsp_data, alu_a}), 32'd0);
    check("rst_exec_flags", 32'({flag_z, flag_v, flag_n, alu_b}), 32'd0);
    have_p = 1'b0; m_last = 1'b1; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) step();
    set_req(1'b0, 4'd0, 16'h0001, 16'h0001);
    set_req(1'b1, 4'd0, 16'h0002, 16'h0002);
    #1 check("post_rst_grant", 32'({req0_ready, req1_ready}), 32'b10);
    repeat (4) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra;
      ra = 16'($urandom);
      if (!req0_valid && $urandom_range(0, 2) == 0)
        set_req(1'b0, 4'($urandom_range(0, 15)), ra, ($urandom_range(0, 3) == 0) ? ra : 16'($urandom));
      if (!req1_valid && $urandom_range(0, 2) == 0)
        set_req(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
